alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer_if.sv | 25 ++
 rtl/alu_op_sequencer.sv | 113 +++++++++++
 tb/tb_alu_op_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/result bus of the multi-cycle ALU sequencer.
// The master issues start/opcode/operands and acknowledges results;
// the slave (the sequencer) publishes ready, the state code and y.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ack;
    logic             ready;
    logic [1:0]       state;
    logic [WIDTH-1:0] y;

    modport master (
        output start, opcode, a, b, ack,
        input  ready, state, y
    );

    modport slave (
        input  start, opcode, a, b, ack,
        output ready, state, y
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU sequencer: add/sub complete on the accept edge,
// multiply (shift-add) and divide (restoring) run one iteration per
// BUSY edge. The result is held in DONE until acknowledged.
module alu_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               resetN,
    alu_op_sequencer_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_div;      // 1: divide in flight, 0: multiply
    logic [WIDTH-1:0]   r_a;        // multiplicand / dividend, shifts left
    logic [WIDTH-1:0]   r_b;        // multiplier (shifts right) / divisor
    logic [WIDTH-1:0]   r_acc;      // product / quotient under construction
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_y;

    logic [WIDTH:0]     w_rem_sh;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;

    // One multiply or divide iteration computed from the current registers.
    // A zero divisor makes every trial subtraction succeed, which yields
    // an all-ones quotient with no special casing.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_rem_sh  = {r_rem, r_a[WIDTH-1]};
        w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
        w_rem_nxt = r_rem;
        w_acc_nxt = r_acc;
        if (r_div) begin
            w_rem_nxt = w_rem_ge ? (w_rem_sh[WIDTH-1:0] - r_b) : w_rem_sh[WIDTH-1:0];
            w_acc_nxt = {r_acc[WIDTH-2:0], w_rem_ge};
        end else begin
            w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetN) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode; an illegal code falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = bus.opcode[1] ? S_BUSY : S_DONE;
            S_BUSY:  if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  if (bus.ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iterations and result register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_div <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_y   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_div <= bus.opcode[0];
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_acc <= '0;
                        r_rem <= '0;
                        if (bus.opcode[1]) begin
                            r_cnt <= CNT_W'(WIDTH - 1);
                        end else begin
                            r_y <= bus.opcode[0] ? (bus.a - bus.b) : (bus.a + bus.b);
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_rem <= w_rem_nxt;
                    r_a   <= r_a << 1;
                    if (!r_div) r_b <= r_b >> 1;
                    if (r_cnt == '0) r_y   <= w_acc_nxt;
                    else             r_cnt <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = (r_state == S_IDLE);
    assign bus.state = r_state;
    assign bus.y     = r_y;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases, protocol
// corner cases and randomized operations compared against an
// arithmetic reference model with per-opcode latency.
module tb_alu_op_sequencer;
    localparam int W = 8;

    logic clock;
    logic resetN;
    int   n_checks;
    int   n_errors;
    logic [W-1:0] exp_y;

    alu_op_sequencer_if #(.WIDTH(W)) bus ();

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference result straight from the arithmetic definitions.
    function automatic logic [W-1:0] ref_result(input logic [1:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        int unsigned ua;
        int unsigned ub;
        ua = 32'(a);
        ub = 32'(b);
        case (op)
            2'd0:    return W'(ua + ub);
            2'd1:    return W'(ua - ub);
            2'd2:    return W'(ua * ub);
            default: return (ub == 0) ? {W{1'b1}} : W'(ua / ub);
        endcase
    endfunction

    // Edges from accept to DONE.
    function automatic int ref_latency(input logic [1:0] op);
        return op[1] ? W + 1 : 1;
    endfunction

    // Issue one op from IDLE (called #1 after an edge); checks the state
    // code and y hold every cycle up to DONE. With ack high, also checks
    // the return to IDLE. pulse_at>0 pulses an ADD 1+1 during BUSY.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int pulse_at);
        logic [W-1:0] res;
        int lat;
        res = ref_result(op, a, b);
        lat = ref_latency(op);
        check("idle_ready", 32'(bus.ready), 32'd1);
        check("idle_state", 32'(bus.state), 32'd0);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.a      = a;
        bus.b      = b;
        @(posedge clock); #1;
        bus.start  = 1'b0;
        bus.opcode = 2'($urandom);
        bus.a      = W'($urandom);
        bus.b      = W'($urandom);
        for (int i = 1; i < lat; i++) begin
            check("busy_state", 32'(bus.state), 32'd1);
            check("busy_ready", 32'(bus.ready), 32'd0);
            check("busy_y_hold", 32'(bus.y), 32'(exp_y));
            if (i == pulse_at) begin
                bus.start  = 1'b1;
                bus.opcode = 2'd0;
                bus.a      = W'(1);
                bus.b      = W'(1);
            end
            @(posedge clock); #1;
            bus.start = 1'b0;
        end
        exp_y = res;
        check("done_state", 32'(bus.state), 32'd2);
        check("done_y", 32'(bus.y), 32'(exp_y));
        if (bus.ack) begin
            @(posedge clock); #1;
            check("ack_idle", 32'(bus.state), 32'd0);
            check("ack_y_hold", 32'(bus.y), 32'(exp_y));
        end
    endtask

    // Hold DONE for some cycles with ack low, then acknowledge.
    task automatic release_done(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check("hold_state", 32'(bus.state), 32'd2);
            check("hold_y", 32'(bus.y), 32'(exp_y));
        end
        bus.ack = 1'b1;
        @(posedge clock); #1;
        bus.ack = 1'b0;
        check("release_state", 32'(bus.state), 32'd0);
        check("release_ready", 32'(bus.ready), 32'd1);
        check("release_y", 32'(bus.y), 32'(exp_y));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        bit           r_ack;

        n_checks   = 0;
        n_errors   = 0;
        exp_y      = '0;
        resetN     = 1'b0;
        bus.start  = 1'b0;
        bus.opcode = 2'd0;
        bus.a      = '0;
        bus.b      = '0;
        bus.ack    = 1'b0;
        #1;
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_ready", 32'(bus.ready), 32'd1);
        check("reset_y", 32'(bus.y), 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("post_reset_idle", 32'(bus.state), 32'd0);
        end

        // Directed arithmetic with explicit acknowledge.
        run_op(2'd0, 8'h05, 8'h03, 0); release_done(0);
        run_op(2'd1, 8'h05, 8'h03, 0); release_done(0);
        run_op(2'd1, 8'h03, 8'h05, 0); release_done(0);
        run_op(2'd0, 8'hFF, 8'h01, 0); release_done(0);
        run_op(2'd2, 8'h05, 8'h03, 3); release_done(5);
        run_op(2'd2, 8'h14, 8'h0A, 0); release_done(0);
        run_op(2'd2, 8'h10, 8'h10, 0); release_done(0);
        run_op(2'd3, 8'hC8, 8'h07, 0); release_done(0);
        run_op(2'd3, 8'h05, 8'h03, 0); release_done(0);
        run_op(2'd3, 8'h2A, 8'h00, 0); release_done(1);

        // ack and start together in DONE: start is dropped, then accepted next edge.
        run_op(2'd0, 8'h01, 8'h02, 0);
        bus.ack    = 1'b1;
        bus.start  = 1'b1;
        bus.opcode = 2'd0;
        bus.a      = 8'h07;
        bus.b      = 8'h09;
        @(posedge clock); #1;
        bus.ack = 1'b0;
        check("ack_start_idle", 32'(bus.state), 32'd0);
        check("ack_start_y", 32'(bus.y), 32'(exp_y));
        @(posedge clock); #1;
        bus.start = 1'b0;
        exp_y = 8'h10;
        check("next_accept_state", 32'(bus.state), 32'd2);
        check("next_accept_y", 32'(bus.y), 32'(exp_y));
        release_done(0);

        // Back-to-back with ack tied high.
        bus.ack = 1'b1;
        run_op(2'd0, 8'h05, 8'h03, 0);
        run_op(2'd2, 8'h05, 8'h03, 0);
        run_op(2'd3, 8'h05, 8'h03, 0);
        run_op(2'd1, 8'h05, 8'h03, 0);
        bus.ack = 1'b0;

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_a   = W'($urandom);
            r_b   = (n % 8 == 7) ? '0 : W'($urandom);
            r_ack = ($urandom_range(0, 1) == 1);
            bus.ack = r_ack;
            run_op(r_op, r_a, r_b, 0);
            if (!r_ack) release_done(int'($urandom_range(0, 2)));
            bus.ack = 1'b0;
        end

        // Reset in the 4th BUSY cycle of a multiply.
        run_op(2'd0, 8'h11, 8'h22, 0); release_done(0);
        bus.start  = 1'b1;
        bus.opcode = 2'd2;
        bus.a      = 8'h05;
        bus.b      = 8'h03;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
        end
        check("pre_reset_busy", 32'(bus.state), 32'd1);
        #2;
        resetN = 1'b0;
        #1;
        exp_y = '0;
        check("async_reset_state", 32'(bus.state), 32'd0);
        check("async_reset_ready", 32'(bus.ready), 32'd1);
        check("async_reset_y", 32'(bus.y), 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("reset_wait_idle", 32'(bus.state), 32'd0);
            check("reset_wait_y", 32'(bus.y), 32'd0);
        end
        run_op(2'd0, 8'h05, 8'h03, 0); release_done(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
